// File: rtl/maxpool_sched.sv
// Sequential max-pool walker: one buffer read per cycle per window, one pooled result per window on a valid/ready stream.
// Define MAXPOOL_SIGNED_EN to compare activations as two's-complement; otherwise the comparison is unsigned.
module maxpool_sched #(
    parameter int IN_W       = 32,
    parameter int IN_H       = 32,
    parameter int CHANNELS   = 16,
    parameter int POOL_SIZE  = 2,
    parameter int ACTIV_BITS = 8,
    parameter int ADDR_BITS  = $clog2(IN_W*IN_H*CHANNELS),
    localparam int OUT_W     = IN_W / POOL_SIZE,
    localparam int OUT_H     = IN_H / POOL_SIZE,
    localparam int CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int X_BITS    = (OUT_W > 1) ? $clog2(OUT_W) : 1,
    localparam int Y_BITS    = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_BITS-1:0]  mem_rd_addr,
    input  logic [ACTIV_BITS-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACTIV_BITS-1:0] out_data,
    output logic [CH_BITS-1:0]    out_ch,
    output logic [X_BITS-1:0]     out_x,
    output logic [Y_BITS-1:0]     out_y,
    output logic [2:0]            dbg_state
);
    localparam int K_BITS = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_EMIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [K_BITS-1:0]  LAST_K = K_BITS'(POOL_SIZE - 1);
    localparam logic [X_BITS-1:0]  LAST_X = X_BITS'(OUT_W - 1);
    localparam logic [Y_BITS-1:0]  LAST_Y = Y_BITS'(OUT_H - 1);
    localparam logic [CH_BITS-1:0] LAST_C = CH_BITS'(CHANNELS - 1);

    logic [2:0]            r_state;
    logic [K_BITS-1:0]     r_kx;
    logic [K_BITS-1:0]     r_ky;
    logic [X_BITS-1:0]     r_ox;
    logic [Y_BITS-1:0]     r_oy;
    logic [CH_BITS-1:0]    r_ch;
    logic [ADDR_BITS-1:0]  r_addr;
    logic                  r_rd_vld;
    logic                  r_rd_first;
    logic [ACTIV_BITS-1:0] r_max;

    logic                  w_last_kx;
    logic                  w_last_k;
    logic [K_BITS-1:0]     w_nkx;
    logic [K_BITS-1:0]     w_nky;
    logic                  w_last_x;
    logic                  w_last_y;
    logic                  w_final;
    logic [X_BITS-1:0]     w_nox;
    logic [Y_BITS-1:0]     w_noy;
    logic [CH_BITS-1:0]    w_nch;
    logic                  w_greater;

    function automatic logic [ADDR_BITS-1:0] f_addr(input int c, input int y, input int x);
        int v;
        v = (c * IN_H + y) * IN_W + x;
        return ADDR_BITS'(v);
    endfunction

    assign w_last_kx = (r_kx == LAST_K);
    assign w_last_k  = w_last_kx && (r_ky == LAST_K);
    assign w_nkx     = w_last_kx ? '0 : r_kx + 1'b1;
    assign w_nky     = w_last_kx ? r_ky + 1'b1 : r_ky;

    assign w_last_x  = (r_ox == LAST_X);
    assign w_last_y  = (r_oy == LAST_Y);
    assign w_final   = w_last_x && w_last_y && (r_ch == LAST_C);
    assign w_nox     = w_last_x ? '0 : r_ox + 1'b1;
    assign w_noy     = w_last_x ? (w_last_y ? '0 : r_oy + 1'b1) : r_oy;
    assign w_nch     = (w_last_x && w_last_y) ? r_ch + 1'b1 : r_ch;

`ifdef MAXPOOL_SIGNED_EN
    assign w_greater = $signed(mem_rd_data) > $signed(r_max);
`else
    assign w_greater = mem_rd_data > r_max;
`endif

    // r_addr always holds the address of the read issued in the current READ cycle and
    // keeps its last value elsewhere, so it is loaded one step ahead on each transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_kx    <= '0;
            r_ky    <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_ch    <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_READ;
                        r_kx    <= '0;
                        r_ky    <= '0;
                        r_ox    <= '0;
                        r_oy    <= '0;
                        r_ch    <= '0;
                        r_addr  <= '0;
                    end
                end
                S_READ: begin
                    if (w_last_k) begin
                        r_state <= S_WAIT;
                        r_kx    <= '0;
                        r_ky    <= '0;
                    end else begin
                        r_kx   <= w_nkx;
                        r_ky   <= w_nky;
                        r_addr <= f_addr(int'(r_ch), int'(r_oy) * POOL_SIZE + int'(w_nky),
                                         int'(r_ox) * POOL_SIZE + int'(w_nkx));
                    end
                end
                S_WAIT: r_state <= S_EMIT;
                S_EMIT: begin
                    if (out_ready) begin
                        if (w_final) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_READ;
                            r_ox    <= w_nox;
                            r_oy    <= w_noy;
                            r_ch    <= w_nch;
                            r_addr  <= f_addr(int'(w_nch), int'(w_noy) * POOL_SIZE,
                                              int'(w_nox) * POOL_SIZE);
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read data lands one cycle after the strobe; the first datum of a window seeds the max.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_vld   <= 1'b0;
            r_rd_first <= 1'b0;
            r_max      <= '0;
        end else begin
            r_rd_vld   <= mem_rd_en;
            r_rd_first <= mem_rd_en && (r_kx == '0) && (r_ky == '0);
            if (r_rd_vld && (r_rd_first || w_greater))
                r_max <= mem_rd_data;
        end
    end

    // out_valid stays high with stable payload until out_ready; transfer happens on valid && ready.
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign mem_rd_en   = (r_state == S_READ);
    assign mem_rd_addr = r_addr;
    assign out_valid   = (r_state == S_EMIT);
    assign out_data    = r_max;
    assign out_ch      = r_ch;
    assign out_x       = r_ox;
    assign out_y       = r_oy;
    assign dbg_state   = r_state;

endmodule

// File: doc/maxpool_sched.md
# maxpool_sched

Sequencer that walks a channel-planar feature map held in an on-chip activation buffer, issues one read per cycle for each POOL_SIZE×POOL_SIZE window, and reduces each window to its maximum. It emits one pooled activation per window on a valid/ready stream. It sits between the activation buffer written by the convolution stage and the downstream flatten or dense stage. It replaces the fully parallel pooling array when area matters more than throughput.

## Interface
- IN_W, 32, input feature-map width in pixels
- IN_H, 32, input feature-map height in pixels
- CHANNELS, 16, number of channels
- POOL_SIZE, 2, window edge length; stride equals POOL_SIZE
- ACTIV_BITS, 8, activation width
- ADDR_BITS, $clog2(IN_W*IN_H*CHANNELS), buffer address width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to pool the whole map; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse after the final output handshake
- mem_rd_en  out  1  buffer read strobe
- mem_rd_addr  out  ADDR_BITS  read address, computed as (c*IN_H + y)*IN_W + x
- mem_rd_data  in  ACTIV_BITS  read data, valid exactly one cycle after mem_rd_en
- out_valid  out  1  pooled result available
- out_ready  in  1  downstream accepts result
- out_data  out  ACTIV_BITS  window maximum
- out_ch  out  $clog2(CHANNELS)  channel of the result
- out_x, out_y  out  $clog2(IN_W/POOL_SIZE), $clog2(IN_H/POOL_SIZE)  output coordinates; each is minimum 1 bit

## Operation
- FSM states: IDLE, READ, WAIT, EMIT, DONE.
- IDLE → READ when start=1. Clear all counters.
- READ lasts POOL_SIZE² cycles.
  - One read is issued per cycle, in kx-fastest order: (ky,kx) = (0,0),(0,1)…(P-1,P-1).
  - x = ox*P + kx, y = oy*P + ky.
- WAIT lasts one cycle. The last read's data returns in this cycle.
- Reduction:
  - A registered 1-cycle-delayed copy of mem_rd_en qualifies mem_rd_data.
  - The first datum of a window loads the max register directly.
  - Each later datum replaces it only if strictly greater. Comparison is unsigned.
- EMIT:
  - Hold out_valid=1, with out_data, out_ch, out_x and out_y stable, until out_ready=1.
  - On the handshake, advance ox, then oy, then c, and go to READ.
  - After the final window (c=CHANNELS-1, oy=IN_H/P-1, ox=IN_W/P-1), go to DONE instead.
- DONE lasts one cycle with done=1, then returns to IDLE.
- Output order is channel outermost, then oy, then ox, giving CHANNELS*(IN_W/P)*(IN_H/P) results per run.
- Non-divisible sizes: trailing columns and rows beyond floor(IN_W/P)*P and floor(IN_H/P)*P are never read.
- start in any state other than IDLE (including DONE) is ignored. It is not queued.
- mem_rd_en is 0 outside READ. mem_rd_addr holds its last value when not reading.

## Timing
- Reset values: busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_ch=0, out_x=0, out_y=0; FSM in IDLE.
- Asserting rst mid-run aborts immediately to the reset values. A partial window is discarded and no done pulse is produced.
- Taking start in cycle 0:
  - Reads occur in cycles 1…P².
  - WAIT occurs in cycle P²+1.
  - out_valid first rises in cycle P²+2.
- With out_ready tied high, the window period is P²+2 cycles.
- Each stalled cycle with out_valid=1 and out_ready=0 adds exactly one cycle. No read is issued during a stall.
- done rises the cycle after the final handshake. busy falls in the same cycle that done falls.
- out_valid never deasserts without a handshake, except on rst.

## Configuration
- MAXPOOL_SIGNED_EN defined:
  - Window comparison treats mem_rd_data and the max register as two's-complement signed.
  - Example: 8'hFF (-1) loses to 8'h01.
- Not defined: comparison is unsigned, so 8'hFF wins. Interface and timing are identical in both builds.

## Test plan
- Reset and idle: hold rst for 3 cycles, then release with start=0 for 20 cycles → all outputs remain 0; no mem_rd_en.
- Single run with IN_W=IN_H=4, CHANNELS=2, P=2, buffer loaded with addr mod 256, out_ready=1 →
  - 8 results in order c,oy,ox.
  - First result out_data=5 with out_valid at cycle 6.
  - Last result 31.
  - done one cycle after the 8th handshake.
- Backpressure: same setup with out_ready low for 5 cycles on result 3 → out_data and coordinates stay stable, no reads during the stall, total run 5 cycles longer.
- Ordering ties and extremes:
  - Window {0x80,0x7F,0x80,0x00} → 0x80 unsigned, 0x7F with MAXPOOL_SIGNED_EN.
  - Window {0xFF,0xFF,0xFF,0xFF} → 0xFF.
- Start ignored: pulse start during READ and during DONE → result count is unchanged and no second run begins.
- Reset mid-run: assert rst during EMIT of result 4, then restart → the restarted run begins at c=0, ox=0, oy=0 with correct values, and no stale done pulse.
